wb_arbiter: RTL and testbench

Writeback arbiter in front of the register file's single write port. It merges two result sources:
- the in-order pipeline's writeback, which has no backpressure and always wins;
- a long-latency unit (load/store or mul/div), buffered in a small FIFO with a valid/ready handshake.

It drives the register file write port from registered outputs, squashes stale buffered results that a younger pipeline write has overtaken (WAW), and exports a pending-destination mask for the hazard unit.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_arbiter_if.sv | 36 +++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/wb_arbiter.sv | 74 +++++++
 tb/tb_wb_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and widths for the writeback arbiter slice.
//   XLEN       - result data width
//   REG_ADDR_W - register specifier width
//   wb_entry_t - one buffered long-latency result (rd, data, WAW kill flag)
//   onehot_rd  - register specifier to 32-bit one-hot mask
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  kill;
  } wb_entry_t;

  function automatic logic [31:0] onehot_rd(input logic [REG_ADDR_W-1:0] rd);
    return 32'(1) << rd;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bus bundle around the writeback arbiter.
//   pipe_*        - in-order pipeline result (no backpressure)
//   lsu_*         - long-latency result, valid/ready handshake
//   WE/writePort* - registered regfile write port
//   pend_mask     - live buffered destinations for the hazard unit
//   fifo_count    - buffer occupancy
// master: result producers / regfile side; slave: the arbiter.
interface wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            WE;
  logic [4:0]      writePortSEL;
  logic [XLEN-1:0] writePort;
  logic [31:0]     pend_mask;
  logic [CW-1:0]   fifo_count;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, WE, writePortSEL, writePort, pend_mask, fifo_count
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, WE, writePortSEL, writePort, pend_mask, fifo_count
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of long-latency results with WAW kill marking.
//   push_en/push_rd/push_data - enqueue (caller gates on space and rd!=0)
//   pop_en/head/empty         - dequeue head entry (caller gates on !empty)
//   kill_en/kill_rd           - mark every held entry targeting kill_rd
//   live_mask                 - one-hot OR of rd over valid, unkilled entries
//   count                     - occupancy, one bit wider than the pointers
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_en,
  input  logic [REG_ADDR_W-1:0]   push_rd,
  input  logic [XLEN-1:0]         push_data,
  input  logic                    pop_en,
  output wb_entry_t               head,
  output logic                    empty,
  input  logic                    kill_en,
  input  logic [REG_ADDR_W-1:0]   kill_rd,
  output logic [31:0]             live_mask,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wptr, rptr;

  assign empty = (count == '0);
  assign head  = mem[rptr];

  // A pop never coincides with a kill (pops only happen without a pipeline
  // write), and push never lands on the head slot unless the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && vld[i] && mem[i].rd == kill_rd) mem[i].kill <= 1'b1;
        if (pop_en && PW'(i) == rptr) vld[i] <= 1'b0;
        if (push_en && PW'(i) == wptr) begin
          vld[i] <= 1'b1;
          // Same-cycle pipeline write to the same rd is younger: enter killed.
          mem[i] <= '{rd: push_rd, data: push_data,
                      kill: kill_en && (push_rd == kill_rd)};
        end
      end
      if (push_en) wptr <= wptr + 1'b1;
      if (pop_en)  rptr <= rptr + 1'b1;
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  always_comb begin
    live_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && !mem[i].kill) live_mask |= onehot_rd(mem[i].rd);
    live_mask[0] = 1'b0;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline writeback (always wins) with buffered
// long-latency results onto the single regfile write port.
//   clk, rst_n - clock, async active-low reset
//   bus        - wb_arbiter_if.slave (pipe/lsu inputs, registered write
//                port, pend_mask, fifo_count, lsu_ready)
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic          clk,
  input logic          rst_n,
  wb_arbiter_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            pipe_wr, push, pop, fifo_empty;
  wb_entry_t       head;
  logic [CW-1:0]   count;
  logic [31:0]     live_mask;
  logic            we_q;
  logic [4:0]      sel_q;
  logic [XLEN-1:0] data_q;

  assign pipe_wr = bus.pipe_valid && (bus.pipe_rd != '0);
  // Gated by occupancy only; a same-cycle pop does not open a full buffer.
  assign bus.lsu_ready = (count < CW'(DEPTH)) && rst_n;
  // rd=0 offers complete the handshake but are dropped.
  assign push = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != '0);
  assign pop  = !fifo_empty && !pipe_wr;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_en   (push),
    .push_rd   (bus.lsu_rd),
    .push_data (bus.lsu_data),
    .pop_en    (pop),
    .head      (head),
    .empty     (fifo_empty),
    .kill_en   (pipe_wr),
    .kill_rd   (bus.pipe_rd),
    .live_mask (live_mask),
    .count     (count)
  );

  // Killed heads still consume a write slot but leave select/data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (pipe_wr) begin
      we_q   <= 1'b1;
      sel_q  <= bus.pipe_rd;
      data_q <= bus.pipe_data;
    end else if (pop) begin
      we_q <= !head.kill;
      if (!head.kill) begin
        sel_q  <= head.rd;
        data_q <= head.data;
      end
    end else begin
      we_q <= 1'b0;
    end
  end

  assign bus.WE           = we_q;
  assign bus.writePortSEL = sel_q;
  assign bus.writePort    = data_q;
  assign bus.pend_mask    = live_mask;
  assign bus.fifo_count   = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed test-plan sequences plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_wb_arbiter;
  import wb_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          kill;
  } ment_t;

  ment_t       q[$];
  logic        m_we;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  logic [31:0] rf  [32];
  logic [31:0] mrf [32];
  int n_cmp = 0;
  int n_err = 0;
  bit hold;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (!q[i].kill) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_sel = '0; m_data = '0;
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.pipe_valid = pv; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.lsu_valid  = lv; bus.lsu_rd  = lrd; bus.lsu_data  = ld;
  endtask

  // Entered at posedge+1 with inputs applied; checks at negedge, advances
  // the model at posedge, returns at posedge+1.
  task automatic cycle();
    bit pw, push, pop;
    ment_t e;
    @(negedge clk);
    chk("we",    64'(bus.WE),           64'(m_we));
    chk("sel",   64'(bus.writePortSEL), 64'(m_sel));
    chk("data",  64'(bus.writePort),    64'(m_data));
    chk("ready", 64'(bus.lsu_ready),    64'(q.size() < DEPTH));
    chk("pend",  64'(bus.pend_mask),    64'(model_mask()));
    chk("count", 64'(bus.fifo_count),   64'(q.size()));
    if (bus.WE) rf[bus.writePortSEL] = bus.writePort;
    if (m_we)   mrf[m_sel] = m_data;
    @(posedge clk);
    pw   = bus.pipe_valid && bus.pipe_rd != 0;
    push = bus.lsu_valid && (q.size() < DEPTH) && bus.lsu_rd != 0;
    pop  = (q.size() > 0) && !pw;
    if (pw) begin
      m_we = 1'b1; m_sel = bus.pipe_rd; m_data = bus.pipe_data;
      foreach (q[i]) if (q[i].rd == bus.pipe_rd) q[i].kill = 1'b1;
    end else if (pop) begin
      e = q.pop_front();
      m_we = !e.kill;
      if (!e.kill) begin m_sel = e.rd; m_data = e.data; end
    end else begin
      m_we = 1'b0;
    end
    if (push) q.push_back('{rd: bus.lsu_rd, data: bus.lsu_data,
                            kill: pw && (bus.lsu_rd == bus.pipe_rd)});
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we",    64'(bus.WE),           64'(0));
    chk("rst_sel",   64'(bus.writePortSEL), 64'(0));
    chk("rst_data",  64'(bus.writePort),    64'(0));
    chk("rst_ready", 64'(bus.lsu_ready),    64'(0));
    chk("rst_pend",  64'(bus.pend_mask),    64'(0));
    chk("rst_count", 64'(bus.fifo_count),   64'(0));
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    hold = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin rf[r] = '0; mrf[r] = '0; end
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("por_we",    64'(bus.WE),           64'(0));
    chk("por_sel",   64'(bus.writePortSEL), 64'(0));
    chk("por_ready", 64'(bus.lsu_ready),    64'(0));
    chk("por_pend",  64'(bus.pend_mask),    64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    chk("idle_ready", 64'(bus.lsu_ready), 64'(1));

    // Pipeline write, then rd=0 pipeline result.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0); cycle();
    chk("p5_we",   64'(bus.WE),           64'(1));
    chk("p5_sel",  64'(bus.writePortSEL), 64'(5));
    chk("p5_data", 64'(bus.writePort),    64'hDEADBEEF);
    drive(1, 0, 32'h12345678, 0, 0, 0); cycle();
    chk("p0_we",   64'(bus.WE), 64'(0));
    idle(1);

    // Back-to-back long-latency pushes drain in order.
    drive(0, 0, 0, 1, 7, 32'h11); cycle();
    drive(0, 0, 0, 1, 8, 32'h22); cycle();
    chk("pend78", 64'(bus.pend_mask[8:7]), 64'(2'b10));
    idle(4);

    // Fill under a continuous pipeline stream, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, $urandom, 1, 5'(10 + i), $urandom); cycle();
    end
    drive(1, 1, $urandom, 0, 0, 0); cycle();
    chk("full_count", 64'(bus.fifo_count), 64'(4));
    chk("full_ready", 64'(bus.lsu_ready),  64'(0));
    idle(6);
    chk("drained", 64'(bus.fifo_count), 64'(0));

    // WAW: younger pipeline write overtakes a buffered result.
    drive(0, 0, 0, 1, 9, 32'hAA); cycle();
    drive(1, 9, 32'hBB, 0, 0, 0); cycle();
    chk("waw_pend9", 64'(bus.pend_mask[9]), 64'(0));
    idle(4);
    chk("waw_rf9", 64'(rf[9]), 64'hBB);

    // Same-cycle push and pipeline write to the same rd.
    drive(1, 3, 32'h33, 1, 3, 32'h44); cycle();
    chk("same_sel",   64'(bus.writePortSEL), 64'(3));
    chk("same_pend3", 64'(bus.pend_mask[3]), 64'(0));
    idle(3);
    chk("same_rf3", 64'(rf[3]), 64'h33);

    // Randomized traffic with an upstream that holds offers until ready.
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      int pbias;
      pbias = ((c / 100) % 2 == 0) ? 40 : 85;
      if (!hold)
        drive(0, 0, 0, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      bus.pipe_valid = ($urandom_range(0, 99) < pbias);
      bus.pipe_rd    = 5'($urandom_range(0, 7));
      bus.pipe_data  = $urandom;
      hold = bus.lsu_valid && !(q.size() < DEPTH);
      cycle();
      if (c == 330 || c == 470) mid_reset();
    end
    idle(8);
    for (int r = 0; r < 32; r++) chk($sformatf("rf%0d", r), 64'(rf[r]), 64'(mrf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
